// File: rtl/nbit_delay_line_pkg.sv
// Shared helpers for the programmable delay line: select-width derivation
// and lane slicing used by both the design and its interface.
package nbit_delay_line_pkg;

    // Bits needed to encode a latency of 0..depth inclusive.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // LSB position of lane c in a packed multi-lane bus of w-bit lanes.
    function automatic int lane_lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/nbit_delay_line_if.sv
// Stream and control bundle for the delay line; master drives samples and
// latency control, slave is the delay line itself.
interface nbit_delay_line_if
    import nbit_delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1,
    parameter int MAX_DEPTH  = 16
);
    localparam int SEL_W = sel_width(MAX_DEPTH);

    logic                           enable;
    logic                           clear;
    logic [SEL_W-1:0]               delay_sel;
    logic                           in_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] out_data;
    logic                           primed;

    modport master (
        output enable, clear, delay_sel, in_valid, in_data,
        input  out_valid, out_data, primed
    );

    modport slave (
        input  enable, clear, delay_sel, in_valid, in_data,
        output out_valid, out_data, primed
    );

endinterface

// File: rtl/nbit_delay_line_stage.sv
// One {valid, data} pipeline register: async reset, clear beats enable.
module nbit_delay_line_stage #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/nbit_delay_line.sv
// Multi-lane delay line with run-time latency select, stall, flush and a
// primed flag telling the consumer the selected tap holds real history.
module nbit_delay_line
    import nbit_delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1,
    parameter int MAX_DEPTH  = 16
) (
    input  logic               clk,
    input  logic               resetn,
    nbit_delay_line_if.slave   bus
);

    localparam int DW    = DATA_WIDTH * CHANNELS;
    localparam int SW    = DW + 1;
    localparam int SEL_W = sel_width(MAX_DEPTH);
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DEPTH);

    logic [SW-1:0]    stage_q [MAX_DEPTH];
    logic [SW-1:0]    tap;
    logic [SEL_W-1:0] eff_sel;
    logic [SEL_W-1:0] fill_cnt_reg;

    generate
        for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
            logic [SW-1:0] stage_d;
            if (gi == 0) begin : g_head
                assign stage_d = {bus.in_valid, bus.in_data};
            end else begin : g_body
                assign stage_d = stage_q[gi-1];
            end
            nbit_delay_line_stage #(.WIDTH(SW)) u_stage (
                .clk    (clk),
                .resetn (resetn),
                .enable (bus.enable),
                .clear  (bus.clear),
                .d      (stage_d),
                .q      (stage_q[gi])
            );
        end
    endgenerate

    // Oversized requests clamp to the deepest tap so the mux never leaves the chain.
    assign eff_sel = (bus.delay_sel > MAX_SEL) ? MAX_SEL : bus.delay_sel;

    always_comb begin
        tap = {bus.in_valid, bus.in_data};
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (eff_sel == SEL_W'(k + 1)) begin
                tap = stage_q[k];
            end
        end
    end

    assign {bus.out_valid, bus.out_data} = tap;

    // Counts enabled shifts since flush, pinned at MAX_DEPTH so it cannot wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_cnt_reg <= '0;
        end else if (bus.clear) begin
            fill_cnt_reg <= '0;
        end else if (bus.enable && (fill_cnt_reg != MAX_SEL)) begin
            fill_cnt_reg <= fill_cnt_reg + SEL_W'(1);
        end
    end

    assign bus.primed = (fill_cnt_reg >= eff_sel);

endmodule

// File: tb/tb_nbit_delay_line.sv
// Self-checking bench: vector table with a latency scoreboard, plus directed
// sequences for async reset, latency change mid-stream and counter saturation.
module tb_nbit_delay_line;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int MD = 16;
    localparam int SW = 5;
    localparam int BW = DW * CH;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    nbit_delay_line_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_DEPTH(MD)) bus ();

    nbit_delay_line #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_DEPTH(MD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int            sc;
        int            sel;
        bit            en;
        bit            clr;
        bit            vld;
        logic [BW-1:0] data;
        bit            exp_primed;
    } vec_t;

    typedef struct {
        logic [BW-1:0] data;
        int            due;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   build_fill;
    int   ecount;
    int   checks;
    int   errors;

    function automatic logic [BW-1:0] mk(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b ^ 8'hA5, b};
    endfunction

    function automatic int eff_of(input int sel);
        return (sel > MD) ? MD : sel;
    endfunction

    // Builds one row; primed expectation follows the enabled-shift count since flush.
    function automatic void add(input int sc, input int sel, input bit en,
                                input bit clr, input bit vld, input logic [BW-1:0] data);
        vec_t v;
        v.sc = sc; v.sel = sel; v.en = en; v.clr = clr; v.vld = vld; v.data = data;
        v.exp_primed = (build_fill >= eff_of(sel));
        vecs.push_back(v);
        if (clr) build_fill = 0;
        else if (en && build_fill < MD) build_fill++;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input bit en, input bit clr, input bit vld,
                         input logic [BW-1:0] data);
        bus.delay_sel = SW'(sel);
        bus.enable    = en;
        bus.clear     = clr;
        bus.in_valid  = vld;
        bus.in_data   = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; ecount = 0; build_fill = 0;

        // Reset state, including bypass behaviour while held in reset
        drive(4, 1'b0, 1'b0, 1'b1, mk(7));
        #2;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_data", 32'(bus.out_data), 32'd0);
        chk("reset primed sel4", 32'(bus.primed), 32'd0);
        bus.delay_sel = SW'(0);
        #1;
        chk("reset primed sel0", 32'(bus.primed), 32'd1);
        chk("reset bypass data", 32'(bus.out_data), 32'(mk(7)));
        chk("reset bypass valid", 32'(bus.out_valid), 32'd1);
        $display("reset: out_valid=%0b out_data=%h primed=%0b", bus.out_valid, bus.out_data, bus.primed);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk) #1;

        // Fixed delay 4, 32 samples
        for (int i = 0; i < 32; i++) add(1, 4, 1'b1, 1'b0, 1'b1, mk(i + 1));
        for (int i = 0; i < 4; i++)  add(1, 4, 1'b1, 1'b0, 1'b0, '0);
        // Stall for two cycles after the second sample
        add(2, 3, 1'b1, 1'b1, 1'b1, mk(99));
        for (int r = 0; r < 14; r++) begin
            if (r == 2 || r == 3) add(2, 3, 1'b0, 1'b0, 1'b1, mk(200 + r));
            else                  add(2, 3, 1'b1, 1'b0, 1'b1, mk(8'h30 + r));
        end
        for (int i = 0; i < 3; i++) add(2, 3, 1'b1, 1'b0, 1'b0, '0);
        // Clear after five samples
        add(3, 3, 1'b1, 1'b1, 1'b1, mk(98));
        for (int i = 0; i < 5; i++) add(3, 3, 1'b1, 1'b0, 1'b1, mk(8'h40 + i));
        add(3, 3, 1'b1, 1'b1, 1'b1, mk(8'h4F));
        for (int i = 0; i < 6; i++) add(3, 3, 1'b1, 1'b0, 1'b1, mk(8'h50 + i));
        for (int i = 0; i < 3; i++) add(3, 3, 1'b1, 1'b0, 1'b0, '0);
        // Bypass, including an idle and a stalled row
        add(4, 0, 1'b1, 1'b1, 1'b1, mk(8'h60));
        for (int i = 0; i < 6; i++) add(4, 0, 1'b1, 1'b0, (i % 2 == 0), mk(8'h61 + i));
        add(4, 0, 1'b0, 1'b0, 1'b1, mk(8'h6F));
        // Out-of-range select clamps to the full 16-stage latency
        add(5, 31, 1'b1, 1'b1, 1'b1, mk(97));
        for (int i = 0; i < 20; i++) add(5, 31, 1'b1, 1'b0, 1'b1, mk(8'h70 + i));
        for (int i = 0; i < 16; i++) add(5, 31, 1'b1, 1'b0, 1'b0, '0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.sel, v.en, v.clr, v.vld, v.data);
            if (v.en && !v.clr && v.vld) sb.push_back('{data: v.data, due: ecount + eff_of(v.sel)});
            #1;
            $display("row %0d sc=%0d sel=%0d en=%0b clr=%0b in=%0b/%h -> out=%0b/%h primed=%0b",
                     i, v.sc, v.sel, v.en, v.clr, v.vld, v.data, bus.out_valid, bus.out_data, bus.primed);
            chk($sformatf("row%0d primed", i), 32'(bus.primed), 32'(v.exp_primed));
            if (v.en && !v.clr) begin
                if (sb.size() > 0 && sb[0].due == ecount) begin
                    chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'd1);
                    chk($sformatf("row%0d out_data", i), 32'(bus.out_data), 32'(sb[0].data));
                    void'(sb.pop_front());
                end else begin
                    chk($sformatf("row%0d idle out_valid", i), 32'(bus.out_valid), 32'd0);
                end
            end
            if (v.clr) sb.delete();
            @(posedge clk);
            if (v.en && !v.clr) ecount++;
            #1;
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        // Latency change 4 -> 2 mid-stream, then saturation of the fill counter
        drive(4, 1'b1, 1'b1, 1'b0, '0);
        @(posedge clk) #1;
        for (int i = 0; i < 40; i++) begin
            drive((i < 8) ? 4 : 2, 1'b1, 1'b0, 1'b1, mk(i));
            #1;
            if (i == 8) begin
                bus.delay_sel = SW'(4);
                #1;
                chk("selchg sel4 data", 32'(bus.out_data), 32'(mk(4)));
                chk("selchg sel4 valid", 32'(bus.out_valid), 32'd1);
                bus.delay_sel = SW'(2);
                #1;
                chk("selchg sel2 data", 32'(bus.out_data), 32'(mk(6)));
                chk("selchg sel2 valid", 32'(bus.out_valid), 32'd1);
            end
            if (i == 20) chk("sel2 steady data", 32'(bus.out_data), 32'(mk(18)));
            $display("selchg cycle %0d sel=%0d out=%0b/%h", i, bus.delay_sel, bus.out_valid, bus.out_data);
            @(posedge clk) #1;
        end
        drive(16, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("saturated primed sel16", 32'(bus.primed), 32'd1);
        chk("sel16 tap data", 32'(bus.out_data), 32'(mk(24)));
        bus.delay_sel = SW'(31);
        #1;
        chk("saturated primed sel31", 32'(bus.primed), 32'd1);
        chk("sel31 clamp data", 32'(bus.out_data), 32'(mk(24)));
        chk("sel31 clamp valid", 32'(bus.out_valid), 32'd1);
        $display("saturation: primed=%0b out=%0b/%h", bus.primed, bus.out_valid, bus.out_data);

        // Asynchronous reset with the pipeline full
        drive(4, 1'b1, 1'b0, 1'b1, mk(77));
        #1;
        chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("async reset out_data", 32'(bus.out_data), 32'd0);
        chk("async reset primed", 32'(bus.primed), 32'd0);
        $display("async reset: out=%0b/%h primed=%0b", bus.out_valid, bus.out_data, bus.primed);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk) #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
